// File: rtl/a2d_spi_resp_pkg.sv
// Shared types and constants for the A2D SPI responder.
package a2d_resp_pkg;

  typedef enum logic [1:0] {
    ARM   = 2'd0,
    IDLE  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  localparam int FRM_BITS = 16;
  localparam int CHNL_MSB = 13;
  localparam int CHNL_LSB = 11;
  localparam int RES_W    = 12;

endpackage

// File: rtl/a2d_spi_resp_if.sv
// SPI pin bundle between the A2D master and the responder.
interface a2d_spi_resp_if;
  logic SS_n;
  logic SCLK;
  logic MOSI;
  logic MISO;

  modport master (output SS_n, output SCLK, output MOSI, input MISO);
  modport slave  (input SS_n, input SCLK, input MOSI, output MISO);
endinterface

// File: rtl/a2d_spi_resp_spi_pin_sync.sv
// Multi-flop synchronizer for one SPI pin plus a history flop for edge pulses.
// SYNC_STG must be at least 2.
module spi_pin_sync #(
  parameter int   SYNC_STG = 2,
  parameter logic RST_VAL  = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_pin,
  output logic o_lvl,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STG-1:0] r_sync;
  logic                r_hist;

  // shift the pin through the sync chain; history holds the previous synced level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {SYNC_STG{RST_VAL}};
      r_hist <= RST_VAL;
    end else begin
      r_sync <= {r_sync[SYNC_STG-2:0], i_pin};
      r_hist <= r_sync[SYNC_STG-1];
    end
  end

  assign o_lvl  = r_sync[SYNC_STG-1];
  assign o_rise =  r_sync[SYNC_STG-1] & ~r_hist;
  assign o_fall = ~r_sync[SYNC_STG-1] &  r_hist;

endmodule

// File: rtl/a2d_spi_resp.sv
// SPI responder standing in for the 8-channel 12-bit A2D converter.
// Decodes {2'b00, chnnl, 11'h0} and returns {4'h0, value} on the next frame.
module a2d_spi_resp
  import a2d_resp_pkg::*;
#(
  parameter int SYNC_STG = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  a2d_spi_resp_if.slave        spi,
  input  logic [8*RES_W-1:0]   i_chan_vals,
  output logic [2:0]           o_chnnl_lat,
  output logic [FRM_BITS-1:0]  o_rx_cmd,
  output logic                 o_frm_vld,
  output logic                 o_frm_err
);

  // ARM must see SS_n high this many consecutive cycles; the sync chain resets
  // high, so a pin held low through reset shows at most SYNC_STG stale highs.
  localparam logic [3:0] ARM_CNT = 4'(SYNC_STG + 1);
  localparam logic [4:0] BITS_5  = 5'(FRM_BITS);

  logic                w_ss_lvl, w_ss_rise, w_ss_fall;
  logic                w_sclk_rise, w_sclk_fall;
  logic                w_mosi;
  logic [RES_W-1:0]    w_chan_sel;

  state_t              r_state;
  logic [3:0]          r_arm_cnt;
  logic [4:0]          r_bit_cnt;
  logic                r_first_fall;
  logic [FRM_BITS-1:0] r_tx_shft;
  logic [FRM_BITS-1:0] r_rx_shft;
  logic                r_end_good;
  logic                r_end_bad;
  logic [SYNC_STG-1:0] r_mosi_sync;
  logic [2:0]          r_chnnl_lat;
  logic [FRM_BITS-1:0] r_rx_cmd;
  logic                r_frm_vld;
  logic                r_frm_err;

  spi_pin_sync #(.SYNC_STG(SYNC_STG), .RST_VAL(1'b1)) u_ss_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_pin  (spi.SS_n),
    .o_lvl  (w_ss_lvl),
    .o_rise (w_ss_rise),
    .o_fall (w_ss_fall)
  );

  spi_pin_sync #(.SYNC_STG(SYNC_STG), .RST_VAL(1'b1)) u_sclk_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_pin  (spi.SCLK),
    .o_lvl  (),
    .o_rise (w_sclk_rise),
    .o_fall (w_sclk_fall)
  );

  // MOSI only needs its level, delayed to line up with the SCLK edge pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_mosi_sync <= '0;
    else        r_mosi_sync <= {r_mosi_sync[SYNC_STG-2:0], spi.MOSI};
  end
  assign w_mosi = r_mosi_sync[SYNC_STG-1];

  assign w_chan_sel = i_chan_vals[RES_W*int'(r_chnnl_lat) +: RES_W];

  // frame FSM: arm, wait for select, shift bits, classify the frame on select release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ARM;
      r_arm_cnt    <= '0;
      r_bit_cnt    <= '0;
      r_first_fall <= 1'b0;
      r_tx_shft    <= '0;
      r_rx_shft    <= '0;
      r_end_good   <= 1'b0;
      r_end_bad    <= 1'b0;
    end else begin
      r_end_good <= 1'b0;
      r_end_bad  <= 1'b0;
      case (r_state)
        ARM: begin
          if (!w_ss_lvl) begin
            r_arm_cnt <= '0;
          end else if (r_arm_cnt == ARM_CNT - 4'd1) begin
            r_arm_cnt <= '0;
            r_state   <= IDLE;
          end else begin
            r_arm_cnt <= r_arm_cnt + 4'd1;
          end
        end
        IDLE: begin
          if (w_ss_fall) begin
            r_tx_shft    <= {4'h0, w_chan_sel};
            r_bit_cnt    <= '0;
            r_first_fall <= 1'b1;
            r_state      <= SHIFT;
          end
        end
        SHIFT: begin
          // select release wins over any SCLK edge landing in the same cycle
          if (w_ss_rise) begin
            r_end_good <= (r_bit_cnt == BITS_5);
            r_end_bad  <= (r_bit_cnt != BITS_5);
            r_state    <= IDLE;
          end else begin
            if (w_sclk_rise) begin
              r_rx_shft <= {r_rx_shft[FRM_BITS-2:0], w_mosi};
              if (r_bit_cnt != 5'd31) r_bit_cnt <= r_bit_cnt + 5'd1;
            end
            // the leading fall only opens the frame; MSB is already on MISO
            if (w_sclk_fall) begin
              if (r_first_fall) r_first_fall <= 1'b0;
              else              r_tx_shft    <= {r_tx_shft[FRM_BITS-2:0], 1'b0};
            end
          end
        end
        default: r_state <= ARM;
      endcase
    end
  end

  // publish frame result one cycle after classification, with the latched command
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frm_vld   <= 1'b0;
      r_frm_err   <= 1'b0;
      r_rx_cmd    <= '0;
      r_chnnl_lat <= '0;
    end else begin
      r_frm_vld <= r_end_good;
      r_frm_err <= r_end_bad;
      if (r_end_good) begin
        r_rx_cmd    <= r_rx_shft;
        r_chnnl_lat <= r_rx_shft[CHNL_MSB:CHNL_LSB];
      end
    end
  end

  assign spi.MISO    = r_tx_shft[FRM_BITS-1];
  assign o_chnnl_lat = r_chnnl_lat;
  assign o_rx_cmd    = r_rx_cmd;
  assign o_frm_vld   = r_frm_vld;
  assign o_frm_err   = r_frm_err;

endmodule

// File: tb/tb_a2d_spi_resp.sv
// Bench for a2d_spi_resp: directed table, random frames against a frame-level
// model, and hand sequences for mid-frame data change, reset and minimum gaps.
module tb_a2d_spi_resp;

  localparam int HALF = 5;   // clk cycles per SCLK phase

  logic        clk = 1'b0;
  logic        rst_n;
  logic [95:0] chan;
  logic [2:0]  o_chnnl_lat;
  logic [15:0] o_rx_cmd;
  logic        o_frm_vld, o_frm_err;

  a2d_spi_resp_if spi();

  a2d_spi_resp #(.SYNC_STG(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .spi         (spi),
    .i_chan_vals (chan),
    .o_chnnl_lat (o_chnnl_lat),
    .o_rx_cmd    (o_rx_cmd),
    .o_frm_vld   (o_frm_vld),
    .o_frm_err   (o_frm_err)
  );

  always #10 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // frame-result scratch shared by the frame tasks
  logic [31:0] rbits;
  int          fv, fe, lat;

  // model state: what the converter last accepted
  logic [2:0]  mdl_chnl;
  logic [15:0] mdl_cmd;

  typedef struct {
    logic [15:0] cmd;
    int          n;
    logic [15:0] exp_resp;
    int          exp_vld;
    int          exp_err;
    logic [2:0]  exp_chnl;
    logic [15:0] exp_rx;
  } vec_t;
  vec_t tbl [5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (o_frm_vld) fv++;
    if (o_frm_err) fe++;
  endtask

  task automatic set_ch(input int k, input logic [11:0] v);
    chan[12*k +: 12] = v;
  endtask

  function automatic logic [31:0] exp_bits(input logic [15:0] r, input int n);
    logic [31:0] e;
    e = '0;
    for (int i = 0; i < n; i++) begin
      if (i < 16) e = {e[30:0], r[15-i]};
      else        e = {e[30:0], 1'b0};
    end
    return e;
  endfunction

  // master: SCLK idles high, MOSI changes on fall, MISO sampled just before rise
  task automatic do_frame(input logic [15:0] cmd, input int n, input int gap);
    rbits = '0; fv = 0; fe = 0; lat = -1;
    spi.SS_n = 1'b0;
    repeat (HALF) tick();
    for (int i = 0; i < n; i++) begin
      spi.SCLK = 1'b0;
      spi.MOSI = (i < 16) ? cmd[15-i] : 1'b0;
      repeat (HALF) tick();
      rbits = {rbits[30:0], spi.MISO};
      spi.SCLK = 1'b1;
      repeat (HALF) tick();
    end
    spi.SS_n = 1'b1;
    for (int c = 1; c <= gap; c++) begin
      tick();
      if (lat < 0 && (o_frm_vld || o_frm_err)) lat = c;
    end
  endtask

  task automatic run_check(input string nm, input logic [15:0] cmd, input int n,
                           input logic [15:0] resp, input int ev, input int ee,
                           input logic [2:0] ech, input logic [15:0] erx, input int gap);
    do_frame(cmd, n, gap);
    chk({nm, ".miso"}, rbits, exp_bits(resp, n));
    chk({nm, ".vld"}, fv, ev);
    chk({nm, ".err"}, fe, ee);
    chk({nm, ".lat"}, lat, 4);
    chk({nm, ".chnl"}, {29'd0, o_chnnl_lat}, {29'd0, ech});
    chk({nm, ".rx"}, {16'd0, o_rx_cmd}, {16'd0, erx});
  endtask

  // frame checked against the model, which then absorbs the frame
  task automatic model_frame(input string nm, input logic [15:0] cmd, input int n, input int gap);
    logic [15:0] resp;
    resp = {4'h0, chan[12*int'(mdl_chnl) +: 12]};
    if (n == 16) begin
      mdl_cmd  = cmd;
      mdl_chnl = cmd[13:11];
    end
    run_check(nm, cmd, n, resp, (n == 16) ? 1 : 0, (n == 16) ? 0 : 1, mdl_chnl, mdl_cmd, gap);
  endtask

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: run exceeded cycle budget");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    spi.SS_n = 1'b1; spi.SCLK = 1'b1; spi.MOSI = 1'b0;
    chan = '0;
    set_ch(0, 12'h123); set_ch(3, 12'hA5C); set_ch(5, 12'h5A5); set_ch(7, 12'h777);

    tbl[0] = '{16'h0000, 16, 16'h0123, 1, 0, 3'd0, 16'h0000};
    tbl[1] = '{16'h1800, 16, 16'h0123, 1, 0, 3'd3, 16'h1800};
    tbl[2] = '{16'h1800, 16, 16'h0A5C, 1, 0, 3'd3, 16'h1800};
    tbl[3] = '{16'h3800,  8, 16'h0A5C, 0, 1, 3'd3, 16'h1800};
    tbl[4] = '{16'h0000, 16, 16'h0A5C, 1, 0, 3'd0, 16'h0000};

    repeat (3) @(negedge clk);
    chk("rst.miso", {31'd0, spi.MISO}, 32'd0);
    chk("rst.chnl", {29'd0, o_chnnl_lat}, 32'd0);
    chk("rst.rx",   {16'd0, o_rx_cmd}, 32'd0);
    chk("rst.vld",  {31'd0, o_frm_vld}, 32'd0);
    chk("rst.err",  {31'd0, o_frm_err}, 32'd0);
    rst_n = 1'b1;
    repeat (6) tick();

    for (int i = 0; i < 5; i++)
      run_check($sformatf("tbl%0d", i), tbl[i].cmd, tbl[i].n, tbl[i].exp_resp,
                tbl[i].exp_vld, tbl[i].exp_err, tbl[i].exp_chnl, tbl[i].exp_rx, 10);
    mdl_chnl = 3'd0;
    mdl_cmd  = 16'h0000;

    // random frames: random data, random commands, occasional bad lengths
    for (int i = 0; i < 40; i++) begin
      int n;
      chan = {$urandom, $urandom, $urandom};
      n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20)) : 16;
      model_frame($sformatf("rnd%0d", i), 16'($urandom), n, 10);
    end

    // channel data changes mid-frame; the response keeps the start-of-frame value
    set_ch(5, 12'hFFF);
    model_frame("sel5", 16'h2800, 16, 10);
    fork
      run_check("hold", 16'h2800, 16, 16'h0FFF, 1, 0, 3'd5, 16'h2800, 10);
      begin
        repeat (HALF + 4*2*HALF) @(negedge clk);
        set_ch(5, 12'h000);
      end
    join
    mdl_chnl = 3'd5; mdl_cmd = 16'h2800;

    // back-to-back frames with the minimum select-high gap
    set_ch(1, 12'h001); set_ch(6, 12'h666);
    model_frame("b2b0", 16'h0800, 16, 4);
    model_frame("b2b1", 16'h3000, 16, 4);
    run_check("b2b2", 16'h3000, 16, 16'h0666, 1, 0, 3'd6, 16'h3000, 10);

    // reset in the middle of a frame with select held low
    fv = 0; fe = 0;
    spi.SS_n = 1'b0;
    repeat (HALF) tick();
    for (int i = 0; i < 3; i++) begin
      spi.SCLK = 1'b0; repeat (HALF) tick();
      spi.SCLK = 1'b1; repeat (HALF) tick();
    end
    rst_n = 1'b0;
    repeat (3) tick();
    chk("mrst.chnl", {29'd0, o_chnnl_lat}, 32'd0);
    chk("mrst.rx",   {16'd0, o_rx_cmd}, 32'd0);
    chk("mrst.miso", {31'd0, spi.MISO}, 32'd0);
    rst_n = 1'b1;
    fv = 0; fe = 0;
    for (int i = 0; i < 13; i++) begin
      spi.SCLK = 1'b0; repeat (HALF) tick();
      spi.SCLK = 1'b1; repeat (HALF) tick();
    end
    spi.SS_n = 1'b1;
    repeat (15) tick();
    chk("mrst.novld", fv, 0);
    chk("mrst.noerr", fe, 0);
    set_ch(0, 12'h9B7);
    mdl_chnl = 3'd0; mdl_cmd = 16'h0000;
    model_frame("post_rst", 16'h2000, 16, 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
